// File: rtl/mor1kx_l15_rr_sched_if.sv
// Transducer <-> L1.5 request/response channel.
// The scheduler drives the request side (master); the L1.5 answers on the response side (slave).
interface mor1kx_l15_rr_sched_if;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic [3:0]  transducer_l15_amo_op;
  logic        transducer_l15_nc;
  logic [2:0]  transducer_l15_size;
  logic [1:0]  transducer_l15_l1rplway;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic [63:0] transducer_l15_data_next_entry;
  logic        transducer_l15_req_ack;

  logic        l15_transducer_header_ack;
  logic        l15_transducer_ack;
  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [1:0]  l15_transducer_error;
  logic        l15_transducer_noncacheable;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [63:0] l15_transducer_data_2;
  logic [63:0] l15_transducer_data_3;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_nc, transducer_l15_size, transducer_l15_l1rplway,
           transducer_l15_address, transducer_l15_data,
           transducer_l15_data_next_entry, transducer_l15_req_ack,
    input  l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_error,
           l15_transducer_noncacheable, l15_transducer_data_0,
           l15_transducer_data_1, l15_transducer_data_2, l15_transducer_data_3
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_nc, transducer_l15_size, transducer_l15_l1rplway,
           transducer_l15_address, transducer_l15_data,
           transducer_l15_data_next_entry, transducer_l15_req_ack,
    output l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_error,
           l15_transducer_noncacheable, l15_transducer_data_0,
           l15_transducer_data_1, l15_transducer_data_2, l15_transducer_data_3
  );
endinterface

// File: rtl/mor1kx_l15_rr_sched.sv
// Round-robin scheduler sharing one L1.5 transducer channel among NUM_REQ requesters,
// one transaction in flight, with a response watchdog and sticky protocol-fault flags.
module mor1kx_l15_rr_sched #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_val,
  input  logic [5*NUM_REQ-1:0]    req_rqtype,
  input  logic [4*NUM_REQ-1:0]    req_amo_op,
  input  logic [NUM_REQ-1:0]      req_nc,
  input  logic [3*NUM_REQ-1:0]    req_size,
  input  logic [2*NUM_REQ-1:0]    req_l1rplway,
  input  logic [40*NUM_REQ-1:0]   req_address,
  input  logic [64*NUM_REQ-1:0]   req_data,
  input  logic [64*NUM_REQ-1:0]   req_data_next_entry,
  input  logic [NUM_REQ-1:0]      req_rsp_ack,
  output logic [NUM_REQ-1:0]      req_header_ack,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      req_rsp_val,
  output logic [3:0]              rsp_returntype,
  output logic [1:0]              rsp_error,
  output logic                    rsp_noncacheable,
  output logic [63:0]             rsp_data_0,
  output logic [63:0]             rsp_data_1,
  output logic [63:0]             rsp_data_2,
  output logic [63:0]             rsp_data_3,
  output logic                    busy,
  output logic [1:0]              grant,
  output logic                    err_timeout,
  output logic                    err_stray,
  mor1kx_l15_rr_sched_if.master   l15
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, HDR, WAIT_RSP} state_t;

  state_t        state, state_d;
  logic [1:0]    rr_ptr, rr_ptr_d, grant_d, pick, grant_next;
  logic [15:0]   wd_cnt;
  logic          wd_fire;
  logic          stray;
  logic [IW-1:0] gidx;
  logic [NUM_REQ-1:0] gsel;

  logic [4:0]  rqtype_a   [NUM_REQ];
  logic [3:0]  amo_op_a   [NUM_REQ];
  logic [2:0]  size_a     [NUM_REQ];
  logic [1:0]  l1rplway_a [NUM_REQ];
  logic [39:0] address_a  [NUM_REQ];
  logic [63:0] data_a     [NUM_REQ];
  logic [63:0] data_nx_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rqtype_a[i]   = req_rqtype[5*i +: 5];
    assign amo_op_a[i]   = req_amo_op[4*i +: 4];
    assign size_a[i]     = req_size[3*i +: 3];
    assign l1rplway_a[i] = req_l1rplway[2*i +: 2];
    assign address_a[i]  = req_address[40*i +: 40];
    assign data_a[i]     = req_data[64*i +: 64];
    assign data_nx_a[i]  = req_data_next_entry[64*i +: 64];
  end

  assign gidx       = grant[IW-1:0];
  assign gsel       = NUM_REQ'(1) << gidx;
  assign grant_next = (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [2:0] sum;
    logic       found;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    pick  = rr_ptr;
    found = 1'b0;
    sum   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = 3'(rr_ptr) + 3'(off);
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      if (!found && req_val[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = 2'(sum);
      end
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    rr_ptr_d = rr_ptr;
    wd_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_val) begin
          grant_d = pick;
          state_d = HDR;
        end
      end
      HDR: begin
        if (l15.l15_transducer_header_ack) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (l15.l15_transducer_val && req_rsp_ack[gidx]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end else if (wd_cnt == 16'(TIMEOUT)) begin
          // Give up on the L1.5 and let the next requester have a turn.
          wd_fire  = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stray = l15.l15_transducer_val && (state != WAIT_RSP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      grant       <= 2'd0;
      wd_cnt      <= 16'd0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      grant       <= grant_d;
      wd_cnt      <= (state == WAIT_RSP) ? wd_cnt + 16'd1 : 16'd0;
      err_timeout <= err_timeout | wd_fire;
      err_stray   <= err_stray | stray;
    end
  end

  assign busy = (state != IDLE);

  assign l15.transducer_l15_val             = (state == HDR) && req_val[gidx];
  assign l15.transducer_l15_rqtype          = rqtype_a[gidx];
  assign l15.transducer_l15_amo_op          = amo_op_a[gidx];
  assign l15.transducer_l15_nc              = req_nc[gidx];
  assign l15.transducer_l15_size            = size_a[gidx];
  assign l15.transducer_l15_l1rplway        = l1rplway_a[gidx];
  assign l15.transducer_l15_address         = address_a[gidx];
  assign l15.transducer_l15_data            = data_a[gidx];
  assign l15.transducer_l15_data_next_entry = data_nx_a[gidx];
  assign l15.transducer_l15_req_ack         = (state == WAIT_RSP) && req_rsp_ack[gidx];

  assign req_header_ack = (state == HDR && l15.l15_transducer_header_ack) ? gsel : '0;
  assign req_ack        = l15.l15_transducer_ack ? gsel : '0;
  assign req_rsp_val    = (state == WAIT_RSP && l15.l15_transducer_val) ? gsel : '0;

  assign rsp_returntype   = l15.l15_transducer_returntype;
  assign rsp_error        = l15.l15_transducer_error;
  assign rsp_noncacheable = l15.l15_transducer_noncacheable;
  assign rsp_data_0       = l15.l15_transducer_data_0;
  assign rsp_data_1       = l15.l15_transducer_data_1;
  assign rsp_data_2       = l15.l15_transducer_data_2;
  assign rsp_data_3       = l15.l15_transducer_data_3;

endmodule

// File: tb/tb_mor1kx_l15_rr_sched.sv
// Directed bench for mor1kx_l15_rr_sched: fairness, single transactions, response stall,
// watchdog, stray response and mid-transaction reset.
module tb_mor1kx_l15_rr_sched;

  localparam logic [39:0] A0 = 40'h00_0000_1000;
  localparam logic [39:0] A1 = 40'h00_0000_2000;
  localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] RSP_D = 64'hDEAD_BEEF_0000_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_val;
  logic [9:0]   req_rqtype;
  logic [7:0]   req_amo_op;
  logic [1:0]   req_nc;
  logic [5:0]   req_size;
  logic [3:0]   req_l1rplway;
  logic [79:0]  req_address;
  logic [127:0] req_data;
  logic [127:0] req_data_next_entry;
  logic [1:0]   req_rsp_ack;
  logic [1:0]   req_header_ack, req_ack, req_rsp_val;
  logic [3:0]   rsp_returntype;
  logic [1:0]   rsp_error;
  logic         rsp_noncacheable;
  logic [63:0]  rsp_data_0, rsp_data_1, rsp_data_2, rsp_data_3;
  logic         busy, err_timeout, err_stray;
  logic [1:0]   grant;

  int checks = 0;
  int errors = 0;

  mor1kx_l15_rr_sched_if l15_if ();

  mor1kx_l15_rr_sched #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_val             (req_val),
    .req_rqtype          (req_rqtype),
    .req_amo_op          (req_amo_op),
    .req_nc              (req_nc),
    .req_size            (req_size),
    .req_l1rplway        (req_l1rplway),
    .req_address         (req_address),
    .req_data            (req_data),
    .req_data_next_entry (req_data_next_entry),
    .req_rsp_ack         (req_rsp_ack),
    .req_header_ack      (req_header_ack),
    .req_ack             (req_ack),
    .req_rsp_val         (req_rsp_val),
    .rsp_returntype      (rsp_returntype),
    .rsp_error           (rsp_error),
    .rsp_noncacheable    (rsp_noncacheable),
    .rsp_data_0          (rsp_data_0),
    .rsp_data_1          (rsp_data_1),
    .rsp_data_2          (rsp_data_2),
    .rsp_data_3          (rsp_data_3),
    .busy                (busy),
    .grant               (grant),
    .err_timeout         (err_timeout),
    .err_stray           (err_stray),
    .l15                 (l15_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE with req_val already driven; runs one full transaction for requester g.
  task automatic txn(input logic [1:0] g, input int hdr_wait, input int rsp_wait, input int ack_hold);
    logic [1:0] oh;
    oh = 2'b01 << g;
    step();
    check("hdr_grant", 64'(grant), 64'(g));
    check("hdr_busy", 64'(busy), 64'd1);
    check("hdr_l15_val", 64'(l15_if.transducer_l15_val), 64'd1);
    check("hdr_address", 64'(l15_if.transducer_l15_address), 64'(g[0] ? A1 : A0));
    check("hdr_data", l15_if.transducer_l15_data, g[0] ? D1 : D0);
    check("hdr_rqtype", 64'(l15_if.transducer_l15_rqtype), 64'(g[0] ? 5'h01 : 5'h00));
    for (int i = 0; i < hdr_wait; i++) begin
      step();
      check("hdr_hold_val", 64'(l15_if.transducer_l15_val), 64'd1);
      check("hdr_no_hack", 64'(req_header_ack), 64'd0);
    end
    l15_if.l15_transducer_header_ack = 1'b1;
    l15_if.l15_transducer_ack        = 1'b1;
    #1;
    check("header_ack", 64'(req_header_ack), 64'(oh));
    check("req_ack", 64'(req_ack), 64'(oh));
    step();
    l15_if.l15_transducer_header_ack = 1'b0;
    l15_if.l15_transducer_ack        = 1'b0;
    #1;
    check("wait_l15_val", 64'(l15_if.transducer_l15_val), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_no_hack", 64'(req_header_ack), 64'd0);
    for (int i = 0; i < rsp_wait; i++) begin
      check("wait_no_rsp", 64'(req_rsp_val), 64'd0);
      step();
    end
    l15_if.l15_transducer_val        = 1'b1;
    l15_if.l15_transducer_data_0     = RSP_D;
    l15_if.l15_transducer_returntype = 4'h5;
    req_rsp_ack = 2'b00;
    #1;
    check("rsp_val", 64'(req_rsp_val), 64'(oh));
    check("rsp_data_0", rsp_data_0, RSP_D);
    check("rsp_returntype", 64'(rsp_returntype), 64'h5);
    for (int i = 0; i < ack_hold; i++) begin
      check("stall_req_ack", 64'(l15_if.transducer_l15_req_ack), 64'd0);
      step();
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_rsp_val", 64'(req_rsp_val), 64'(oh));
    end
    req_rsp_ack = oh;
    #1;
    check("rsp_req_ack", 64'(l15_if.transducer_l15_req_ack), 64'd1);
    step();
    l15_if.l15_transducer_val    = 1'b0;
    l15_if.l15_transducer_data_0 = 64'd0;
    req_rsp_ack = 2'b00;
    #1;
    check("done_busy", 64'(busy), 64'd0);
    check("done_rsp_val", 64'(req_rsp_val), 64'd0);
    check("done_grant", 64'(grant), 64'(g));
  endtask

  initial begin
    rst                 = 1'b0;
    req_val             = 2'b00;
    req_rqtype          = {5'h01, 5'h00};
    req_amo_op          = {4'h2, 4'h1};
    req_nc              = 2'b10;
    req_size            = {3'd3, 3'd2};
    req_l1rplway        = {2'd1, 2'd0};
    req_address         = {A1, A0};
    req_data            = {D1, D0};
    req_data_next_entry = {~D1, ~D0};
    req_rsp_ack         = 2'b00;
    l15_if.l15_transducer_header_ack   = 1'b0;
    l15_if.l15_transducer_ack          = 1'b0;
    l15_if.l15_transducer_val          = 1'b0;
    l15_if.l15_transducer_returntype   = 4'h0;
    l15_if.l15_transducer_error        = 2'b00;
    l15_if.l15_transducer_noncacheable = 1'b0;
    l15_if.l15_transducer_data_0       = 64'd0;
    l15_if.l15_transducer_data_1       = 64'd0;
    l15_if.l15_transducer_data_2       = 64'd0;
    l15_if.l15_transducer_data_3       = 64'd0;

    // Reset state
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_stray", 64'(err_stray), 64'd0);
    check("rst_l15_val", 64'(l15_if.transducer_l15_val), 64'd0);
    check("rst_req_ack_out", 64'(l15_if.transducer_l15_req_ack), 64'd0);
    check("rst_hack", 64'(req_header_ack), 64'd0);
    check("rst_rsp_val", 64'(req_rsp_val), 64'd0);

    // Both requesters from reset: icache first, then strict alternation
    rst     = 1'b1;
    req_val = 2'b11;
    txn(2'd0, 0, 0, 0);
    txn(2'd1, 0, 1, 0);
    txn(2'd0, 1, 0, 0);
    txn(2'd1, 0, 0, 0);

    // Single dcache load: header ack 2 cycles late, response 5 cycles after it
    req_val = 2'b10;
    txn(2'd1, 2, 4, 0);

    // Requester stalls the response for 3 cycles
    req_val = 2'b01;
    txn(2'd0, 0, 0, 3);

    // Watchdog: rr_ptr = 1 but only icache requests, so it wraps to 0
    step();
    check("wd_grant", 64'(grant), 64'd0);
    l15_if.l15_transducer_header_ack = 1'b1;
    step();
    l15_if.l15_transducer_header_ack = 1'b0;
    req_val = 2'b00;
    for (int i = 0; i < 8; i++) begin
      step();
      check("wd_not_yet", 64'(err_timeout), 64'd0);
      check("wd_busy", 64'(busy), 64'd1);
    end
    step();
    check("wd_fired", 64'(err_timeout), 64'd1);
    check("wd_idle", 64'(busy), 64'd0);
    check("wd_no_rsp_val", 64'(req_rsp_val), 64'd0);

    // Stray response in IDLE
    l15_if.l15_transducer_val = 1'b1;
    req_rsp_ack = 2'b11;
    #1;
    check("stray_rsp_val", 64'(req_rsp_val), 64'd0);
    check("stray_req_ack", 64'(l15_if.transducer_l15_req_ack), 64'd0);
    check("stray_before", 64'(err_stray), 64'd0);
    step();
    l15_if.l15_transducer_val = 1'b0;
    req_rsp_ack = 2'b00;
    #1;
    check("stray_flag", 64'(err_stray), 64'd1);
    check("stray_idle", 64'(busy), 64'd0);

    // Reset in WAIT_RSP; rr_ptr = 1 after the watchdog, so dcache wins
    req_val = 2'b10;
    step();
    check("pre_rst_grant", 64'(grant), 64'd1);
    l15_if.l15_transducer_header_ack = 1'b1;
    step();
    l15_if.l15_transducer_header_ack = 1'b0;
    req_val = 2'b00;
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_grant", 64'(grant), 64'd0);
    check("async_rst_err_timeout", 64'(err_timeout), 64'd0);
    check("async_rst_err_stray", 64'(err_stray), 64'd0);
    check("async_rst_l15_val", 64'(l15_if.transducer_l15_val), 64'd0);
    repeat (2) step();
    rst     = 1'b1;
    req_val = 2'b10;
    txn(2'd1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
